// File: rtl/obstacle_scheduler_pkg.sv
// ============================================================================
// Module   : obstacle_scheduler_pkg
// Brief    : Shared types and constants for the obstacle scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obstacle_scheduler_pkg;

    localparam int NUM_LANES      = 3;
    localparam int OBSTACLE_WIDTH = 32;
    localparam int POS_W          = 11;

    // One table entry as seen by the renderer and death detector.
    typedef struct packed {
        logic             active;
        logic [1:0]       lane;
        logic [POS_W-1:0] position;
    } obstacle_t;

    // Tick-processing sequence.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADVANCE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SPAWN   = 2'd3
    } state_t;

    // Fold the two random LFSR bits onto the three lanes (3 reuses lane 1).
    function automatic logic [1:0] lane_from_bits(input logic [1:0] bits);
        return (bits == 2'd3) ? 2'd1 : bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_scheduler_lfsr16.sv
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit Galois LFSR, taps 16,14,13,11; non-zero seed keeps it
//            out of the all-zero lock-up state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        system_clock_in,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] r_state;

    // Shift right, feeding the output bit back into the tap positions.
    always_ff @(posedge system_clock_in or posedge reset) begin
        if (reset) begin
            r_state <= SEED;
        end else if (step) begin
            r_state <= r_state[0] ? ((r_state >> 1) ^ 16'hB400) : (r_state >> 1);
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/obstacle_scheduler.sv
// ============================================================================
// Module   : obstacle_scheduler
// Brief    : Owns the obstacle table; advances, retires and spawns obstacles
//            once per game tick and ramps the scroll speed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int          NUM_SLOTS        = 10,
    parameter int          SPAWN_POS        = 640,
    parameter int          SPEED_INIT       = 2,
    parameter int          SPEED_MAX        = 12,
    parameter int          SPEED_STEP_TICKS = 600,
    parameter int          MIN_GAP          = 20,
    parameter logic [7:0]  GAP_MASK         = 8'h3F,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                      system_clock_in,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      run,
    input  logic                      died,
    output obstacle_t [NUM_SLOTS-1:0] obstacles,
    output logic [3:0]                speed,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               passed_count,
    output logic                      overrun
);

    localparam int               CNT_W        = $clog2(SPEED_STEP_TICKS);
    localparam logic [3:0]       c_idx_last   = 4'(NUM_SLOTS - 1);
    localparam logic [3:0]       c_no_free    = 4'hF;
    localparam logic [POS_W-1:0] c_spawn_pos  = POS_W'(SPAWN_POS);
    localparam logic [POS_W-1:0] c_lane_limit = POS_W'(SPAWN_POS - 2 * OBSTACLE_WIDTH);
    localparam logic [3:0]       c_speed_init = 4'(SPEED_INIT);
    localparam logic [3:0]       c_speed_max  = 4'(SPEED_MAX);
    localparam logic [CNT_W-1:0] c_step_last  = CNT_W'(SPEED_STEP_TICKS - 1);
    localparam logic [7:0]       c_min_gap    = 8'(MIN_GAP);

    state_t                    r_state;
    obstacle_t [NUM_SLOTS-1:0] r_table;
    logic [3:0]                r_idx;
    logic [3:0]                r_spd;
    logic [1:0]                r_cand;
    logic [3:0]                r_free;
    logic [POS_W-1:0]          r_lane_max;
    logic [7:0]                r_spawn_timer;
    logic [CNT_W-1:0]          r_tick_cnt;
    logic [3:0]                r_speed;
    logic                      r_busy;
    logic                      r_frame_done;
    logic [15:0]               r_passed;
    logic                      r_overrun;

    logic [15:0]               w_lfsr;
    logic                      w_unused_lfsr_hi;
    obstacle_t                 w_cur;
    obstacle_t                 w_upd;
    logic                      w_retire;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .system_clock_in (system_clock_in),
        .reset           (reset),
        .step            (1'b1),
        .state           (w_lfsr)
    );

    // Only the low byte drives lane choice and gap jitter.
    assign w_unused_lfsr_hi = ^w_lfsr[15:8];

    // Next value of the slot currently visited by the advance sweep.
    always_comb begin
        w_cur    = r_table[r_idx];
        w_upd    = w_cur;
        w_retire = 1'b0;
        if (w_cur.active) begin
            if (w_cur.position > POS_W'(r_spd)) begin
                w_upd.position = w_cur.position - POS_W'(r_spd);
            end else begin
                w_upd.active   = 1'b0;
                w_upd.position = '0;
                w_retire       = 1'b1;
            end
        end
    end

    // Tick sequencer: sweep the table, decide on a spawn, then write it.
    always_ff @(posedge system_clock_in or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_table       <= '0;
            r_idx         <= '0;
            r_spd         <= '0;
            r_cand        <= '0;
            r_free        <= c_no_free;
            r_lane_max    <= '0;
            r_spawn_timer <= c_min_gap;
            r_tick_cnt    <= '0;
            r_speed       <= c_speed_init;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_passed      <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (tick && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (tick && run && !died) begin
                        r_spd      <= r_speed;
                        r_cand     <= lane_from_bits(w_lfsr[1:0]);
                        r_idx      <= '0;
                        r_free     <= c_no_free;
                        r_lane_max <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    r_table[r_idx] <= w_upd;
                    if (w_retire && (r_passed != 16'hFFFF)) begin
                        r_passed <= r_passed + 16'd1;
                    end
                    if (!w_upd.active && (r_free == c_no_free)) begin
                        r_free <= r_idx;
                    end
                    if (w_upd.active && (w_upd.lane == r_cand) && (w_upd.position > r_lane_max)) begin
                        r_lane_max <= w_upd.position;
                    end
                    if (r_idx == c_idx_last) begin
                        r_state <= ST_DECIDE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_DECIDE: begin
                    if (r_tick_cnt == c_step_last) begin
                        r_tick_cnt <= '0;
                        if (r_speed < c_speed_max) begin
                            r_speed <= r_speed + 4'd1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                    if (r_spawn_timer != 8'd0) begin
                        r_spawn_timer <= r_spawn_timer - 8'd1;
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_frame_done  <= 1'b1;
                    end else if ((r_free != c_no_free) && (r_lane_max < c_lane_limit)) begin
                        r_state <= ST_SPAWN;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_SPAWN: begin
                    r_table[r_free] <= '{active: 1'b1, lane: r_cand, position: c_spawn_pos};
                    r_spawn_timer   <= c_min_gap + (w_lfsr[7:0] & GAP_MASK);
                    r_state         <= ST_IDLE;
                    r_busy          <= 1'b0;
                    r_frame_done    <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign obstacles    = r_table;
    assign speed        = r_speed;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign passed_count = r_passed;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
// ============================================================================
// Module   : tb_obstacle_scheduler
// Brief    : Randomized self-checking bench for obstacle_scheduler against a
//            tick-level reference model of the obstacle table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obstacle_scheduler;
    import obstacle_scheduler_pkg::*;

    localparam int          NS    = 10;
    localparam int          SPAWN = 640;
    localparam int          SINIT = 2;
    localparam int          SMAX  = 12;
    localparam int          STEP  = 50;     // short ramp so saturation is reached quickly
    localparam int          MING  = 20;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               tick = 1'b0;
    logic               run = 1'b0;
    logic               died = 1'b0;
    obstacle_t [NS-1:0] obstacles;
    logic [3:0]         speed;
    logic               busy;
    logic               frame_done;
    logic [15:0]        passed_count;
    logic               overrun;

    always #5 clk = ~clk;

    obstacle_scheduler #(
        .NUM_SLOTS        (NS),
        .SPAWN_POS        (SPAWN),
        .SPEED_INIT       (SINIT),
        .SPEED_MAX        (SMAX),
        .SPEED_STEP_TICKS (STEP),
        .MIN_GAP          (MING),
        .GAP_MASK         (8'h3F),
        .LFSR_SEED        (SEED)
    ) dut (
        .system_clock_in (clk),
        .reset           (rst),
        .tick            (tick),
        .run             (run),
        .died            (died),
        .obstacles       (obstacles),
        .speed           (speed),
        .busy            (busy),
        .frame_done      (frame_done),
        .passed_count    (passed_count),
        .overrun         (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit          m_act [NS];
    int          m_lane[NS];
    int          m_pos [NS];
    int          m_timer;
    int          m_ticks;
    int          m_passed;
    bit          m_overrun;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [159:0] model_table();
        logic [159:0] t;
        t = '0;
        for (int i = 0; i < NS; i++) begin
            t[i*14 +: 14] = {m_act[i], m_lane[i][1:0], m_pos[i][10:0]};
        end
        return t;
    endfunction

    function automatic int model_speed();
        int s;
        s = SINIT + m_ticks / STEP;
        return (s > SMAX) ? SMAX : s;
    endfunction

    task automatic step();
        @(posedge clk);
        m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 1'b0; m_lane[i] = 0; m_pos[i] = 0;
        end
        m_timer = MING; m_ticks = 0; m_passed = 0; m_overrun = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_table"},  160'(obstacles),    model_table());
        check({tag, "_speed"},  160'(speed),        160'(model_speed()));
        check({tag, "_passed"}, 160'(passed_count), 160'(m_passed));
        check({tag, "_overrun"}, 160'(overrun),     160'(m_overrun));
        check({tag, "_busy"},   160'(busy),         160'(0));
    endtask

    // One tick pulse; run/died must already be set for this tick.
    task automatic run_tick(input bit inject);
        logic [15:0] l0, ls;
        int  spd, cand, free_i, lmax, lat;
        bit  spawn;
        if (!(run && !died)) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            check("frozen_busy", 160'(busy), 160'(0));
            step();
            check("frozen_table", 160'(obstacles), model_table());
            return;
        end
        l0   = m_lfsr;
        spd  = model_speed();
        cand = (l0[1:0] == 2'd3) ? 1 : int'(l0[1:0]);
        free_i = -1;
        lmax = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (m_pos[i] > spd) begin
                    m_pos[i] -= spd;
                end else begin
                    m_act[i] = 1'b0;
                    m_pos[i] = 0;
                    if (m_passed < 65535) m_passed++;
                end
            end
            if (!m_act[i] && free_i < 0) free_i = i;
            if (m_act[i] && m_lane[i] == cand && m_pos[i] > lmax) lmax = m_pos[i];
        end
        m_ticks++;
        spawn = 1'b0;
        if (m_timer != 0) begin
            m_timer--;
        end else if (free_i >= 0 && lmax < SPAWN - 2 * OBSTACLE_WIDTH) begin
            spawn = 1'b1;
            ls = l0;
            for (int k = 0; k < NS + 2; k++) ls = lfsr_next(ls);
            m_act[free_i]  = 1'b1;
            m_lane[free_i] = cand;
            m_pos[free_i]  = SPAWN;
            m_timer = MING + int'(ls[7:0] & 8'h3F);
        end

        tick = 1'b1;
        step();
        tick = 1'b0;
        check("tick_busy", 160'(busy), 160'(1));
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (inject && k == 4) tick = 1'b1;
            if (k == 6) run = ($urandom_range(0, 3) != 0);
            step();
            if (inject && k == 4) begin
                tick = 1'b0;
                m_overrun = 1'b1;
            end
            if (frame_done) begin
                lat = k + 1;
                break;
            end
        end
        check("latency", 160'(lat), 160'(NS + (spawn ? 3 : 2)));
        check_outputs("frame");
    endtask

    initial begin
        model_clear();
        do_reset();
        check("reset_table",   160'(obstacles),    160'(0));
        check("reset_speed",   160'(speed),        160'(SINIT));
        check("reset_busy",    160'(busy),         160'(0));
        check("reset_passed",  160'(passed_count), 160'(0));
        check("reset_overrun", 160'(overrun),      160'(0));
        check("reset_fdone",   160'(frame_done),   160'(0));

        // First twenty ticks only count the spawn timer down.
        run = 1'b1;
        for (int t = 0; t < 20; t++) begin
            run = 1'b1;
            run_tick(1'b0);
        end
        check("no_spawn_20", 160'(obstacles), 160'(0));
        run = 1'b1;
        run_tick(1'b0);
        check("spawn21_active", 160'(obstacles[0].active),   160'(1));
        check("spawn21_pos",    160'(obstacles[0].position), 160'(SPAWN));

        // Randomized play: freezes, deaths and overlapping tick pulses.
        for (int t = 0; t < 900; t++) begin
            run  = ($urandom_range(0, 7) != 0);
            died = ($urandom_range(0, 15) == 0);
            run_tick($urandom_range(0, 19) == 0);
            repeat ($urandom_range(0, 2)) step();
        end
        died = 1'b0;
        if (m_ticks >= STEP * (SMAX - SINIT)) begin
            check("speed_saturated", 160'(speed), 160'(SMAX));
        end
        check("retired_some", 160'(passed_count != 16'd0), 160'(m_passed != 0));

        // Asynchronous reset in the middle of the advance sweep.
        run  = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("midreset_table",   160'(obstacles),    160'(0));
        check("midreset_speed",   160'(speed),        160'(SINIT));
        check("midreset_busy",    160'(busy),         160'(0));
        check("midreset_passed",  160'(passed_count), 160'(0));
        check("midreset_overrun", 160'(overrun),      160'(0));
        check("midreset_fdone",   160'(frame_done),   160'(0));
        do_reset();
        repeat (3) step();
        check_outputs("postreset");
        run_tick(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
